// File: rtl/ocsim_data_source.sv
// ocsim_data_source: valid/ready stream source with a small internal queue,
// an optional auto-incrementing pattern generator and a random duty-cycle
// gate on launches.
// Control that a bench would normally drive through tasks is exposed as
// ports:
//   running      start/stop new launches (a presented beat is never withdrawn).
//   dutyCycle    launch probability in percent; values above 100 act as 100.
//   patternEn    fill empty slots with patternNext when the queue is empty.
//   patternLoad  one-cycle pulse that loads patternNext from patternSeed.
//   sendValid    push sendData; it lands behind any queued entries.
//   sendReady    low when the queue is full.
// When the queue is empty, a pushed item may launch in the same cycle it is
// pushed, so an item offered before posedge N is valid right after posedge N.
// Depth must be a power of two so the queue pointers wrap naturally.
module ocsim_data_source #(
  parameter type Type = logic [31:0],
  parameter int Depth = 16,
  localparam int AddrW = $clog2(Depth)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             running,
  input  logic [7:0]       dutyCycle,
  input  logic             patternEn,
  input  logic             patternLoad,
  input  Type              patternSeed,
  input  logic             sendValid,
  input  Type              sendData,
  output logic             sendReady,
  output Type              outData,
  output logic             outValid,
  input  logic             outReady,
  output logic [31:0]      count,
  output logic             idle,
  output logic [AddrW:0]   queueLevel
);

  Type              memReg [Depth];
  logic [AddrW-1:0] wrPtrReg;
  logic [AddrW-1:0] rdPtrReg;
  logic [AddrW:0]   levelReg;
  logic [AddrW:0]   levelNext;
  logic             outValidReg;
  logic             outValidNext;
  Type              outDataReg;
  Type              outDataNext;
  Type              patternNextReg;
  Type              patternNextNext;
  logic [31:0]      countReg;
  logic [15:0]      lfsrReg;
  logic             lfsrFeedback;

  logic [7:0]       dutyClamped;
  logic             randHit;
  logic             queueEmpty;
  logic             queueFull;
  logic             pushAccept;
  logic             slotFree;
  logic             launchOk;
  logic             popFifo;
  logic             bypass;
  logic             usePattern;
  logic             writeFifo;

  // Launch decision: queued items first, then a same-cycle push, then pattern.
  always_comb begin
    dutyClamped  = (dutyCycle > 8'd100) ? 8'd100 : dutyCycle;
    // Remainder is 0..99, so 100% always hits and 0% never does.
    randHit      = (lfsrReg % 16'd100) < {8'd0, dutyClamped};
    lfsrFeedback = lfsrReg[15] ^ lfsrReg[13] ^ lfsrReg[12] ^ lfsrReg[10];
    queueEmpty   = (levelReg == '0);
    queueFull    = (levelReg == (AddrW+1)'(Depth));
    pushAccept   = sendValid && !queueFull;
    slotFree     = !outValidReg || outReady;
    launchOk     = slotFree && running && randHit;
    popFifo      = launchOk && !queueEmpty;
    bypass       = launchOk && queueEmpty && pushAccept;
    usePattern   = launchOk && queueEmpty && !pushAccept && patternEn;
    writeFifo    = pushAccept && !bypass;
    levelNext    = levelReg + (AddrW+1)'(writeFifo) - (AddrW+1)'(popFifo);
  end

  // Output beat selection; an unaccepted beat is held untouched.
  always_comb begin
    outValidNext    = outValidReg;
    outDataNext     = outDataReg;
    patternNextNext = patternNextReg;
    if (slotFree) begin
      outValidNext = popFifo || bypass || usePattern;
      if (popFifo) begin
        outDataNext = memReg[rdPtrReg];
      end else if (bypass) begin
        outDataNext = sendData;
      end else if (usePattern) begin
        outDataNext = patternNextReg;
      end
    end
    if (patternLoad) begin
      patternNextNext = patternSeed;
    end else if (usePattern) begin
      patternNextNext = patternNextReg + Type'(1);
    end
  end

  // Control state; reset drops any in-flight beat without counting it.
  always_ff @(posedge clock) begin
    if (reset) begin
      outValidReg    <= 1'b0;
      outDataReg     <= '0;
      wrPtrReg       <= '0;
      rdPtrReg       <= '0;
      levelReg       <= '0;
      countReg       <= '0;
      patternNextReg <= patternSeed;
      lfsrReg        <= 16'hACE1;
    end else begin
      outValidReg    <= outValidNext;
      outDataReg     <= outDataNext;
      levelReg       <= levelNext;
      patternNextReg <= patternNextNext;
      lfsrReg        <= {lfsrReg[14:0], lfsrFeedback};
      if (outValidReg && outReady) begin
        countReg <= countReg + 32'd1;
      end
      if (writeFifo) begin
        wrPtrReg <= wrPtrReg + AddrW'(1);
      end
      if (popFifo) begin
        rdPtrReg <= rdPtrReg + AddrW'(1);
      end
    end
  end

  // Queue storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clock) begin
    if (!reset && writeFifo) begin
      memReg[wrPtrReg] <= sendData;
    end
  end

  assign outValid   = outValidReg;
  assign outData    = outDataReg;
  assign count      = countReg;
  assign sendReady  = !queueFull;
  assign idle       = queueEmpty && !outValidReg;
  assign queueLevel = levelReg;

endmodule
